// File: rtl/arbiter_puf.sv
// Behavioural arbiter PUF: N_RESP additive-delay chains driven by a registered challenge.
// Weights are elaboration-time constants from xorshift32(SEED) or a fixed test pattern.
module arbiter_puf #(
  parameter int          N_STAGES  = 16,
  parameter int          N_RESP    = 4,
  parameter int          W_DELTA   = 8,
  parameter logic [31:0] SEED      = 32'hA5C31E7B,
  parameter bit          TEST_MODE = 1'b0
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic [N_STAGES-1:0] SW,
  output logic [N_RESP-1:0]   LD
);

  localparam int W_SUM = W_DELTA + $clog2(N_STAGES);
  localparam int N_W   = N_RESP * N_STAGES;

  function automatic logic [31:0] xorshift32(input logic [31:0] s);
    logic [31:0] t;
    t = s ^ (s << 13);
    t = t ^ (t >> 17);
    t = t ^ (t << 5);
    return t;
  endfunction

  // Weight n = k*N_STAGES+i is taken after step n+1 of the generator.
  function automatic logic [N_W*W_DELTA-1:0] gen_weights();
    logic [31:0]            s;
    logic [N_W*W_DELTA-1:0] w;
    s = (SEED == 32'd0) ? 32'd1 : SEED;
    w = '0;
    for (int n = 0; n < N_W; n++) begin
      s = xorshift32(s);
      if (TEST_MODE) begin
        w[n*W_DELTA +: W_DELTA] = ((n % N_STAGES) == (n / N_STAGES)) ? W_DELTA'(16) : W_DELTA'(1);
      end else begin
        w[n*W_DELTA +: W_DELTA] = s[W_DELTA-1:0];
      end
    end
    return w;
  endfunction

  // phi[i] is negative when an odd number of stages at or above i are crossed.
  function automatic logic suffix_parity(input logic [N_STAGES-1:0] c, input int i);
    return ^(c >> i);
  endfunction

  localparam logic [N_W*W_DELTA-1:0] WEIGHTS = gen_weights();

  logic [N_STAGES-1:0]       chal_q;
  logic [N_STAGES-1:0]       phi_neg;
  logic signed [W_SUM-1:0]   delta;
  logic signed [W_SUM-1:0]   term;
  logic signed [W_DELTA-1:0] w_ki;
  logic [N_RESP-1:0]         resp;

  // Accumulate the signed delay difference per chain and take its strict sign.
  always_comb begin
    phi_neg = '0;
    delta   = '0;
    term    = '0;
    w_ki    = '0;
    resp    = '0;
    for (int i = 0; i < N_STAGES; i++) begin
      phi_neg[i] = suffix_parity(chal_q, i);
    end
    for (int k = 0; k < N_RESP; k++) begin
      delta = '0;
      for (int i = 0; i < N_STAGES; i++) begin
        w_ki = WEIGHTS[(k*N_STAGES+i)*W_DELTA +: W_DELTA];
        term = W_SUM'(w_ki);
        if (phi_neg[i]) begin
          delta = delta - term;
        end else begin
          delta = delta + term;
        end
      end
      // A tie resolves to 0: the bottom path wins.
      resp[k] = ~delta[W_SUM-1] & (|delta);
    end
  end

  // Two-stage pipeline: challenge register then response register.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      chal_q <= '0;
      LD     <= '0;
    end else begin
      chal_q <= SW;
      LD     <= resp;
    end
  end

endmodule

// File: tb/tb_arbiter_puf.sv
// Scoreboard bench for arbiter_puf: directed test-mode vectors plus PRNG-weight checks
// across default, alternate and zero seeds.
module tb_arbiter_puf;

  logic        CLK;
  logic        RST_N;
  logic [15:0] SW;
  logic [3:0]  ld_t, ld_p, ld_s, ld_z;
  logic [3:0][3:0] ld_all;

  localparam logic [31:0] SEED_DEF = 32'hA5C31E7B;
  localparam logic [31:0] SEED_ALT = 32'h12345678;

  arbiter_puf #(.TEST_MODE(1'b1)) dut_t (.CLK(CLK), .RST_N(RST_N), .SW(SW), .LD(ld_t));
  arbiter_puf #(.TEST_MODE(1'b0)) dut_p (.CLK(CLK), .RST_N(RST_N), .SW(SW), .LD(ld_p));
  arbiter_puf #(.TEST_MODE(1'b0), .SEED(SEED_ALT)) dut_s (.CLK(CLK), .RST_N(RST_N), .SW(SW), .LD(ld_s));
  arbiter_puf #(.TEST_MODE(1'b0), .SEED(32'h0)) dut_z (.CLK(CLK), .RST_N(RST_N), .SW(SW), .LD(ld_z));

  assign ld_all = {ld_z, ld_s, ld_p, ld_t};

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [3:0][3:0] exp;
    logic            use_seed_cmp;
  } entry_t;

  entry_t      sbq[$];
  int          compared   = 0;
  int          mismatched = 0;
  int          seed_diff  = 0;
  logic [15:0] chal_m     = 16'h0;
  logic [15:0] hist[1000];

  string names[4] = '{"ld_test", "ld_seed_def", "ld_seed_alt", "ld_seed_zero"};

  // Independent reference: signed-int sums over explicit +/-1 feature products.
  function automatic logic [3:0] model(input logic [31:0] seed, input bit tm, input logic [15:0] c);
    int          w[4][16];
    int          phi[16];
    int          p, d;
    logic [31:0] s;
    logic [3:0]  r;
    s = (seed == 32'd0) ? 32'd1 : seed;
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 16; i++) begin
        s = s ^ (s << 13);
        s = s ^ (s >> 17);
        s = s ^ (s << 5);
        w[k][i] = tm ? ((i == k) ? 16 : 1) : int'($signed(s[7:0]));
      end
    end
    p = 1;
    for (int i = 15; i >= 0; i--) begin
      if (c[i]) p = -p;
      phi[i] = p;
    end
    r = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      d = 0;
      for (int i = 0; i < 16; i++) d = d + w[k][i] * phi[i];
      r[k] = (d > 0);
    end
    return r;
  endfunction

  // One cycle of stimulus; queues the LD expected after the coming rising edge.
  task automatic step(input logic [15:0] sw_v, input logic rst_v, input logic [3:0] hand,
                      input bit use_hand, input bit seed_cmp);
    entry_t e;
    @(negedge CLK);
    SW    = sw_v;
    RST_N = rst_v;
    if (!rst_v) begin
      e.exp = '0;
    end else begin
      e.exp[0] = use_hand ? hand : model(32'h0, 1'b1, chal_m);
      e.exp[1] = model(SEED_DEF, 1'b0, chal_m);
      e.exp[2] = model(SEED_ALT, 1'b0, chal_m);
      e.exp[3] = model(32'h1, 1'b0, chal_m);
    end
    e.use_seed_cmp = seed_cmp;
    sbq.push_back(e);
    chal_m = rst_v ? sw_v : 16'h0;
  endtask

  // Monitor: one response per rising edge, checked away from the edge.
  initial begin
    entry_t e;
    forever begin
      @(posedge CLK);
      #2;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        for (int d = 0; d < 4; d++) begin
          compared++;
          if (ld_all[d] !== e.exp[d]) begin
            mismatched++;
            $display("FAIL %s: got %b expected %b at %0t", names[d], ld_all[d], e.exp[d], $time);
          end
        end
        if (e.use_seed_cmp && (ld_p != ld_s)) seed_diff++;
      end
    end
  end

  typedef struct {
    logic [15:0] sw;
    logic        rst;
    logic [3:0]  exp;
  } vec_t;

  // Hand-computed test-mode responses, including pipeline lag and reset flushes.
  vec_t dir[23] = '{
    '{16'hFFFF, 1'b0, 4'b0000}, '{16'hFFFF, 1'b0, 4'b0000}, '{16'hFFFF, 1'b0, 4'b0000},
    '{16'hFFFF, 1'b1, 4'b1111}, '{16'h0000, 1'b1, 4'b0101}, '{16'hF000, 1'b1, 4'b1111},
    '{16'h0002, 1'b1, 4'b1111}, '{16'h000F, 1'b1, 4'b1100}, '{16'h0004, 1'b1, 4'b0101},
    '{16'h0001, 1'b1, 4'b1000}, '{16'h0000, 1'b1, 4'b1110}, '{16'hF000, 1'b1, 4'b1111},
    '{16'h0F00, 1'b1, 4'b1111}, '{16'h00F0, 1'b1, 4'b1111}, '{16'hFFFF, 1'b1, 4'b1111},
    '{16'h0002, 1'b1, 4'b0101}, '{16'h0004, 1'b1, 4'b1100}, '{16'hFFFF, 1'b1, 4'b1000},
    '{16'h000F, 1'b0, 4'b0000}, '{16'hFFFF, 1'b1, 4'b1111}, '{16'h0001, 1'b1, 4'b0101},
    '{16'h0000, 1'b1, 4'b1110}, '{16'h0000, 1'b1, 4'b1111}
  };

  initial begin
    RST_N = 1'b0;
    SW    = 16'h0;
    for (int n = 0; n < 23; n++) step(dir[n].sw, dir[n].rst, dir[n].exp, 1'b1, 1'b0);
    for (int n = 0; n < 1000; n++) begin
      hist[n] = 16'($urandom);
      step(hist[n], 1'b1, 4'b0000, 1'b0, 1'b1);
    end
    // Replay earlier challenges: responses must repeat exactly.
    for (int n = 0; n < 64; n++) step(hist[n], 1'b1, 4'b0000, 1'b0, 1'b0);
    step(16'h0, 1'b1, 4'b0000, 1'b0, 1'b0);
    step(16'h0, 1'b1, 4'b0000, 1'b0, 1'b0);
    repeat (3) @(posedge CLK);
    #4;
    compared++;
    if (sbq.size() != 0) begin
      mismatched++;
      $display("FAIL drain: got %0d pending expected 0", sbq.size());
    end
    compared++;
    if (seed_diff < 250) begin
      mismatched++;
      $display("FAIL seed_sensitivity: got %0d differing expected >= 250", seed_diff);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
